parity_frame_tx: RTL

Transmit-side counterpart of the 6-bit odd-parity checker. The block accepts a 5-bit data word over a valid/ready handshake and computes the odd-parity bit (parity = XNOR of the five data bits, so the 6-bit word has an odd count of ones). It emits the 6-bit word `{parity, data}` in parallel for the checker and serializes it as a framed bit stream (start, 5 data, parity, stop). It sits between the data source and the link or checker under test.

---
 rtl/parity_tx_pkg.sv | 21 ++
 rtl/odd_parity_gen.sv | 11 +
 rtl/parity_frame_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/parity_tx_pkg.sv
// Shared types, widths and the odd-parity helper for the parity frame transmitter.
package parity_tx_pkg;

  localparam int DATA_W     = 5;
  localparam int FRAME_W    = 6;
  localparam int FRAME_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Odd parity: the returned bit makes the {p, d} word carry an odd count of ones.
  function automatic logic odd_parity(logic [DATA_W-1:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/odd_parity_gen.sv
// Combinational 5-bit odd-parity generator; also used as the golden model on the checker side.
module odd_parity_gen
  import parity_tx_pkg::*;
(
  input  logic [DATA_W-1:0] d,
  output logic              p
);

  assign p = odd_parity(d);

endmodule

// File: rtl/parity_frame_tx.sv
// Accepts a 5-bit word, emits {parity, data} in parallel and as a framed serial stream
// (start, d0..d4, parity, stop). Optional parity-error injection under PARITY_TX_ERR_INJ_EN.
module parity_frame_tx
  import parity_tx_pkg::*;
#(
  parameter int BIT_CYCLES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  in_data,
  output logic               in_ready,
`ifdef PARITY_TX_ERR_INJ_EN
  input  logic               err_inj,
`endif
  output logic [FRAME_W-1:0] frame_out,
  output logic               frame_valid,
  output logic               tx_out,
  output logic               busy,
  output tx_state_t          state_dbg
);

  localparam int CNT_W     = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int STOP_LAST = (BIT_CYCLES > 1) ? BIT_CYCLES - 2 : 0;

  // Handshake: a word transfers at a rising edge where in_valid && in_ready.
  // The source holds in_valid/in_data stable until that edge.

  tx_state_t          state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         idx;
  logic [DATA_W-1:0]  shreg;
  logic               par;
  logic               p_calc;
  logic               p_next;
  logic               bit_end;
  logic               handshake;

  odd_parity_gen u_par (
    .d (in_data),
    .p (p_calc)
  );

`ifdef PARITY_TX_ERR_INJ_EN
  assign p_next = p_calc ^ err_inj;
`else
  assign p_next = p_calc;
`endif

  assign in_ready  = (state == IDLE) && !rst;
  assign handshake = in_valid && in_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;
  assign bit_end   = (cnt == CNT_W'(BIT_CYCLES - 1));

  // The last cycle of the stop bit is spent in IDLE (line already high) so the
  // next word can be accepted exactly 8*BIT_CYCLES after the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      idx         <= '0;
      shreg       <= '0;
      par         <= 1'b0;
      frame_out   <= '0;
      frame_valid <= 1'b0;
      tx_out      <= 1'b1;
    end else begin
      frame_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          tx_out <= 1'b1;
          cnt    <= '0;
          if (handshake) begin
            state       <= START;
            idx         <= '0;
            shreg       <= in_data;
            par         <= p_next;
            frame_out   <= {p_next, in_data};
            frame_valid <= 1'b1;
            tx_out      <= 1'b0;
          end
        end
        START: begin
          if (bit_end) begin
            state  <= DATA;
            cnt    <= '0;
            tx_out <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (idx == 3'd4) begin
              state  <= PARITY;
              tx_out <= par;
            end else begin
              idx    <= idx + 3'd1;
              shreg  <= shreg >> 1;
              tx_out <= shreg[1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PARITY: begin
          if (bit_end) begin
            cnt    <= '0;
            tx_out <= 1'b1;
            if (BIT_CYCLES == 1) state <= IDLE;
            else                 state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == CNT_W'(STOP_LAST)) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
